// File: rtl/pcie_rst_pkg.sv
// Shared types and helpers for the ECP5 PCIe SERDES/PCS reset sequencer.
// Holds the top and lane state encodings, the reset-level constants and the counter-width helpers.
package pcie_rst_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN    = 3'd0,
    ST_RST_DUAL = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_TX_PCS   = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAIL     = 3'd5
  } top_state_t;

  typedef enum logic [1:0] {
    L_RST   = 2'd0,
    L_WAIT  = 2'd1,
    L_READY = 2'd2
  } lane_state_t;

  localparam logic       RST_ON   = 1'b1;
  localparam logic       RST_OFF  = 1'b0;
  // Loss indicators come out of reset reading "bad" until real samples arrive.
  localparam logic [1:0] SYNC_RST = 2'b11;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pcie_rx_lane_rst.sv
// Per-lane RX reset sequencer: synchronises LOS/CDR-LOL, walks L_RST -> L_WAIT -> L_READY.
// lane_ok drops in the same cycle a synced fault is seen so link status can react without extra lag.
module pcie_rx_lane_rst
  import pcie_rst_pkg::*;
#(
  parameter int T_RST_CYC = 32,
  parameter int T_CDR_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx_los,
  input  logic        rx_cdr_lol,
  output logic        rx_serdes_rst_c,
  output logic        rx_pcs_rst_c,
  output logic        lane_rdy,
  output logic        lane_ok,
  output lane_state_t dbg_state
);

  localparam int CNT_W = cnt_w(max3(T_RST_CYC, T_CDR_CYC, 1));
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] CDR_LAST = CNT_W'(T_CDR_CYC - 1);

  logic [1:0]       los_sync;
  logic [1:0]       cdr_sync;
  logic [CNT_W-1:0] cnt;
  lane_state_t      state;
  logic             bad;

  assign bad       = los_sync[1] | cdr_sync[1];
  assign lane_ok   = lane_rdy & ~bad;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      los_sync        <= SYNC_RST;
      cdr_sync        <= SYNC_RST;
      state           <= L_RST;
      cnt             <= '0;
      rx_serdes_rst_c <= RST_ON;
      rx_pcs_rst_c    <= RST_ON;
      lane_rdy        <= 1'b0;
    end else begin
      los_sync <= {los_sync[0], rx_los};
      cdr_sync <= {cdr_sync[0], rx_cdr_lol};
      if (!en) begin
        state           <= L_RST;
        cnt             <= '0;
        rx_serdes_rst_c <= RST_ON;
        rx_pcs_rst_c    <= RST_ON;
        lane_rdy        <= 1'b0;
      end else begin
        case (state)
          L_RST: begin
            if (cnt == RST_LAST) begin
              state           <= L_WAIT;
              cnt             <= '0;
              rx_serdes_rst_c <= RST_OFF;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          L_WAIT: begin
            // Any fault restarts the stability window from zero.
            if (bad) begin
              cnt <= '0;
            end else if (cnt == CDR_LAST) begin
              state        <= L_READY;
              cnt          <= '0;
              rx_pcs_rst_c <= RST_OFF;
              lane_rdy     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          L_READY: begin
            if (bad) begin
              state           <= L_RST;
              cnt             <= '0;
              rx_serdes_rst_c <= RST_ON;
              rx_pcs_rst_c    <= RST_ON;
              lane_rdy        <= 1'b0;
            end
          end
          default: begin
            state <= L_RST;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pcie_serdes_rst_seq.sv
// SERDES/PCS power-up and reset sequencer for the ECP5 PCIe hard core (x1/x2/x4).
// Top FSM owns power-down, dual/TX resets and PLL-lock retry; per-lane FSMs own the RX resets.
module pcie_serdes_rst_seq
  import pcie_rst_pkg::*;
#(
  parameter int NUM_LANES    = 1,
  parameter int T_PDB_CYC    = 250,
  parameter int T_RST_CYC    = 32,
  parameter int T_LOCK_CYC   = 500,
  parameter int T_PLL_TO_CYC = 100000,
  parameter int T_CDR_CYC    = 500,
  parameter int MAX_RETRY    = 3
) (
  input  logic                             sys_clk_125,
  input  logic                             rst,
  input  logic                             pll_lol,
  input  logic [NUM_LANES-1:0]             rx_cdr_lol,
  input  logic [NUM_LANES-1:0]             rx_los,
  input  logic                             force_retrain,
  output logic                             serdes_pdb,
  output logic                             tx_pwrup_c,
  output logic                             serdes_rst_dual_c,
  output logic                             tx_serdes_rst_c,
  output logic                             tx_pcs_rst_c,
  output logic [NUM_LANES-1:0]             rx_serdes_rst_c,
  output logic [NUM_LANES-1:0]             rx_pcs_rst_c,
  output logic                             sli_rst,
  output logic [NUM_LANES-1:0]             lane_rdy,
  output logic                             link_rdy,
  output logic [cnt_w(MAX_RETRY)-1:0]      retry_cnt,
  output logic                             fail,
  output top_state_t                       dbg_state,
  output logic [NUM_LANES-1:0][1:0]        dbg_lane_state
);

  localparam int RETRY_W = cnt_w(MAX_RETRY);
  localparam int PH_W    = cnt_w(max3(T_PDB_CYC, T_RST_CYC, T_PLL_TO_CYC));
  localparam int LOCK_W  = cnt_w(T_LOCK_CYC);
  localparam logic [PH_W-1:0]    PDB_LAST  = PH_W'(T_PDB_CYC - 1);
  localparam logic [PH_W-1:0]    RST_LAST  = PH_W'(T_RST_CYC - 1);
  localparam logic [PH_W-1:0]    TO_LAST   = PH_W'(T_PLL_TO_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(T_LOCK_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  top_state_t           state;
  logic [PH_W-1:0]      ph_cnt;
  logic [LOCK_W-1:0]    lock_cnt;
  logic [1:0]           pll_sync;
  logic                 pll_lol_s;
  logic [RETRY_W-1:0]   retry_inc;
  logic [NUM_LANES-1:0] lane_ok;
  logic                 lane_en;

  assign pll_lol_s = pll_sync[1];
  assign retry_inc = retry_cnt + 1'b1;
  assign lane_en   = (state == ST_RUN);
  assign dbg_state = state;

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      state             <= ST_PWRDN;
      ph_cnt            <= '0;
      lock_cnt          <= '0;
      serdes_pdb        <= 1'b0;
      tx_pwrup_c        <= 1'b0;
      serdes_rst_dual_c <= RST_ON;
      tx_serdes_rst_c   <= RST_ON;
      tx_pcs_rst_c      <= RST_ON;
      retry_cnt         <= '0;
      fail              <= 1'b0;
    end else if (force_retrain && (state != ST_PWRDN)) begin
      state             <= ST_RST_DUAL;
      ph_cnt            <= '0;
      lock_cnt          <= '0;
      serdes_rst_dual_c <= RST_ON;
      tx_serdes_rst_c   <= RST_ON;
      tx_pcs_rst_c      <= RST_ON;
      retry_cnt         <= '0;
      fail              <= 1'b0;
    end else begin
      case (state)
        ST_PWRDN: begin
          if (ph_cnt == PDB_LAST) begin
            state      <= ST_RST_DUAL;
            ph_cnt     <= '0;
            serdes_pdb <= 1'b1;
            tx_pwrup_c <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_RST_DUAL: begin
          if (ph_cnt == RST_LAST) begin
            state             <= ST_PLL_WAIT;
            ph_cnt            <= '0;
            lock_cnt          <= '0;
            serdes_rst_dual_c <= RST_OFF;
            tx_serdes_rst_c   <= RST_OFF;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_PLL_WAIT: begin
          if (pll_lol_s) lock_cnt <= '0;
          else if (lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
          if (ph_cnt != TO_LAST) ph_cnt <= ph_cnt + 1'b1;
          // A lock completing on the timeout cycle still counts as locked.
          if (!pll_lol_s && (lock_cnt == LOCK_LAST)) begin
            state    <= ST_TX_PCS;
            ph_cnt   <= '0;
            lock_cnt <= '0;
          end else if (ph_cnt == TO_LAST) begin
            retry_cnt         <= retry_inc;
            ph_cnt            <= '0;
            lock_cnt          <= '0;
            serdes_rst_dual_c <= RST_ON;
            tx_serdes_rst_c   <= RST_ON;
            if (retry_inc == RETRY_MAX) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              state <= ST_RST_DUAL;
            end
          end
        end
        ST_TX_PCS: begin
          if (ph_cnt == RST_LAST) begin
            state        <= ST_RUN;
            ph_cnt       <= '0;
            tx_pcs_rst_c <= RST_OFF;
            retry_cnt    <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (pll_lol_s) begin
            state             <= ST_RST_DUAL;
            ph_cnt            <= '0;
            serdes_rst_dual_c <= RST_ON;
            tx_serdes_rst_c   <= RST_ON;
            tx_pcs_rst_c      <= RST_ON;
          end
        end
        ST_FAIL: begin
          serdes_pdb        <= 1'b1;
          serdes_rst_dual_c <= RST_ON;
          tx_serdes_rst_c   <= RST_ON;
          tx_pcs_rst_c      <= RST_ON;
          fail              <= 1'b1;
        end
        default: begin
          state  <= ST_PWRDN;
          ph_cnt <= '0;
        end
      endcase
    end
  end

  // link_rdy also looks at this cycle's synced faults so it drops with the lane, not one cycle after.
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      pll_sync <= SYNC_RST;
      sli_rst  <= RST_ON;
      link_rdy <= 1'b0;
    end else begin
      pll_sync <= {pll_sync[0], pll_lol};
      sli_rst  <= serdes_rst_dual_c | tx_serdes_rst_c | ~serdes_pdb | ~tx_pwrup_c;
      link_rdy <= lane_en & ~pll_lol_s & ~force_retrain & (&lane_ok);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pcie_rx_lane_rst #(
      .T_RST_CYC (T_RST_CYC),
      .T_CDR_CYC (T_CDR_CYC)
    ) u_lane (
      .clk             (sys_clk_125),
      .rst             (rst),
      .en              (lane_en),
      .rx_los          (rx_los[g]),
      .rx_cdr_lol      (rx_cdr_lol[g]),
      .rx_serdes_rst_c (rx_serdes_rst_c[g]),
      .rx_pcs_rst_c    (rx_pcs_rst_c[g]),
      .lane_rdy        (lane_rdy[g]),
      .lane_ok         (lane_ok[g]),
      .dbg_state       (dbg_lane_state[g])
    );
  end

endmodule

// File: tb/tb_pcie_serdes_rst_seq.sv
// Bench for pcie_serdes_rst_seq: expected event cycles are queued when stimulus is applied
// and popped when the watched output condition appears.
module tb_pcie_serdes_rst_seq;
  import pcie_rst_pkg::*;

  localparam int NL = 2, T_PDB = 4, T_RST = 3, T_LOCK = 5, T_TO = 20, T_CDR = 6, MAXR = 2;
  localparam int LIMIT = 200;

  localparam int EV_PDB = 0, EV_PWRUP = 1, EV_TXS_LO = 2, EV_SLI_LO = 3, EV_RDY0 = 4,
                 EV_RDY1 = 5, EV_LINK = 6, EV_LINK_LO = 7, EV_PCS0 = 8, EV_TXPCS = 9,
                 EV_ST_DUAL = 10, EV_RXS_ALL = 11, EV_RXP_ALL = 12, EV_RETRY1 = 13,
                 EV_ST_FAIL = 14, EV_FAIL = 15, EV_NOFAIL = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 pll_lol;
  logic [NL-1:0]        rx_cdr_lol;
  logic [NL-1:0]        rx_los;
  logic                 force_retrain;
  logic                 serdes_pdb, tx_pwrup_c, serdes_rst_dual_c, tx_serdes_rst_c, tx_pcs_rst_c;
  logic [NL-1:0]        rx_serdes_rst_c, rx_pcs_rst_c, lane_rdy;
  logic                 sli_rst, link_rdy, fail;
  logic [1:0]           retry_cnt;
  top_state_t           dbg_state;
  logic [NL-1:0][1:0]   dbg_lane_state;

  pcie_serdes_rst_seq #(
    .NUM_LANES(NL), .T_PDB_CYC(T_PDB), .T_RST_CYC(T_RST), .T_LOCK_CYC(T_LOCK),
    .T_PLL_TO_CYC(T_TO), .T_CDR_CYC(T_CDR), .MAX_RETRY(MAXR)
  ) dut (
    .sys_clk_125(clk), .rst(rst), .pll_lol(pll_lol), .rx_cdr_lol(rx_cdr_lol), .rx_los(rx_los),
    .force_retrain(force_retrain), .serdes_pdb(serdes_pdb), .tx_pwrup_c(tx_pwrup_c),
    .serdes_rst_dual_c(serdes_rst_dual_c), .tx_serdes_rst_c(tx_serdes_rst_c),
    .tx_pcs_rst_c(tx_pcs_rst_c), .rx_serdes_rst_c(rx_serdes_rst_c), .rx_pcs_rst_c(rx_pcs_rst_c),
    .sli_rst(sli_rst), .lane_rdy(lane_rdy), .link_rdy(link_rdy), .retry_cnt(retry_cnt),
    .fail(fail), .dbg_state(dbg_state), .dbg_lane_state(dbg_lane_state)
  );

  // Edges since reset release; read on the falling edge it equals the edge just taken.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      EV_PDB:     return serdes_pdb === 1'b1;
      EV_PWRUP:   return tx_pwrup_c === 1'b1;
      EV_TXS_LO:  return tx_serdes_rst_c === 1'b0;
      EV_SLI_LO:  return sli_rst === 1'b0;
      EV_RDY0:    return lane_rdy[0] === 1'b1;
      EV_RDY1:    return lane_rdy[1] === 1'b1;
      EV_LINK:    return link_rdy === 1'b1;
      EV_LINK_LO: return link_rdy === 1'b0;
      EV_PCS0:    return rx_pcs_rst_c[0] === 1'b1;
      EV_TXPCS:   return tx_pcs_rst_c === 1'b1;
      EV_ST_DUAL: return dbg_state === ST_RST_DUAL;
      EV_RXS_ALL: return rx_serdes_rst_c === {NL{1'b1}};
      EV_RXP_ALL: return rx_pcs_rst_c === {NL{1'b1}};
      EV_RETRY1:  return retry_cnt === 2'd1;
      EV_ST_FAIL: return dbg_state === ST_FAIL;
      EV_FAIL:    return fail === 1'b1;
      EV_NOFAIL:  return fail === 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

  // Driver/monitor tasks
  task automatic wait_evt(input int which, output logic [31:0] at);
    int n = 0;
    while (!cond(which) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    at = cond(which) ? 32'(cyc) : 32'hFFFF_FFFF;
  endtask

  task automatic expect_evt(input string tag, input int which);
    logic [31:0] got;
    logic [31:0] exp;
    exp = exp_q.pop_front();
    wait_evt(which, got);
    check(tag, got, exp);
  endtask

  task automatic check_reset(input string p);
    check({p, "_pdb"},      32'(serdes_pdb),        32'd0);
    check({p, "_pwrup"},    32'(tx_pwrup_c),        32'd0);
    check({p, "_dual"},     32'(serdes_rst_dual_c), 32'd1);
    check({p, "_txs"},      32'(tx_serdes_rst_c),   32'd1);
    check({p, "_txpcs"},    32'(tx_pcs_rst_c),      32'd1);
    check({p, "_rxs"},      32'(rx_serdes_rst_c),   32'd3);
    check({p, "_rxp"},      32'(rx_pcs_rst_c),      32'd3);
    check({p, "_sli"},      32'(sli_rst),           32'd1);
    check({p, "_lane_rdy"}, 32'(lane_rdy),          32'd0);
    check({p, "_link"},     32'(link_rdy),          32'd0);
    check({p, "_retry"},    32'(retry_cnt),         32'd0);
    check({p, "_fail"},     32'(fail),              32'd0);
    check({p, "_state"},    32'(dbg_state),         32'(ST_PWRDN));
  endtask

  task automatic restart();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int c0;
  int bring_up;

  initial begin
    rst = 1'b1; pll_lol = 1'b0; rx_los = '0; rx_cdr_lol = '0; force_retrain = 1'b0;
    bring_up = T_PDB + T_RST + T_LOCK + T_RST;  // edge at which the top FSM reaches RUN
    repeat (3) @(negedge clk);
    check_reset("por");

    // Nominal bring-up
    rst = 1'b0;
    exp_q.push_back(T_PDB);
    exp_q.push_back(T_PDB);
    exp_q.push_back(T_PDB + T_RST);
    exp_q.push_back(T_PDB + T_RST + 1);
    exp_q.push_back(bring_up + T_RST + T_CDR);
    exp_q.push_back(bring_up + T_RST + T_CDR);
    exp_q.push_back(bring_up + T_RST + T_CDR + 1);
    expect_evt("nom_pdb", EV_PDB);
    expect_evt("nom_pwrup", EV_PWRUP);
    expect_evt("nom_txs_fall", EV_TXS_LO);
    check("nom_sli_lag", 32'(sli_rst), 32'd1);
    expect_evt("nom_sli_fall", EV_SLI_LO);
    expect_evt("nom_rdy0", EV_RDY0);
    expect_evt("nom_rdy1", EV_RDY1);
    expect_evt("nom_link", EV_LINK);
    check("nom_state_run", 32'(dbg_state), 32'(ST_RUN));
    check("nom_retry", 32'(retry_cnt), 32'd0);

    // Lane 1 CDR glitch seen by the lane at stable count 4
    restart();
    repeat (bring_up + T_RST + 2) @(negedge clk);
    rx_cdr_lol[1] = 1'b1;
    @(negedge clk);
    rx_cdr_lol[1] = 1'b0;
    exp_q.push_back(bring_up + T_RST + T_CDR);
    exp_q.push_back(bring_up + T_RST + T_CDR + 5);
    exp_q.push_back(bring_up + T_RST + T_CDR + 6);
    expect_evt("gl_rdy0", EV_RDY0);
    check("gl_rdy1_late", 32'(lane_rdy[1]), 32'd0);
    expect_evt("gl_rdy1", EV_RDY1);
    expect_evt("gl_link", EV_LINK);

    // Lane 0 loss of signal while running
    repeat (2) @(negedge clk);
    c0 = cyc;
    rx_los[0] = 1'b1;
    @(negedge clk);
    rx_los[0] = 1'b0;
    exp_q.push_back(c0 + 3);
    exp_q.push_back(c0 + 3);
    exp_q.push_back(c0 + 3 + T_RST + T_CDR);
    exp_q.push_back(c0 + 4 + T_RST + T_CDR);
    expect_evt("los_pcs0", EV_PCS0);
    expect_evt("los_link_lo", EV_LINK_LO);
    check("los_rdy1_kept", 32'(lane_rdy[1]), 32'd1);
    check("los_rdy0_lo", 32'(lane_rdy[0]), 32'd0);
    expect_evt("los_rdy0", EV_RDY0);
    expect_evt("los_link", EV_LINK);
    check("los_rdy1_end", 32'(lane_rdy[1]), 32'd1);

    // PLL loss of lock while running
    repeat (2) @(negedge clk);
    c0 = cyc;
    pll_lol = 1'b1;
    @(negedge clk);
    pll_lol = 1'b0;
    exp_q.push_back(c0 + 3);
    exp_q.push_back(c0 + 3);
    exp_q.push_back(c0 + 4);
    exp_q.push_back(c0 + 4);
    exp_q.push_back(c0 + 3 + T_RST);
    exp_q.push_back(c0 + 3 + bring_up - T_PDB + T_RST + T_CDR + 1);
    expect_evt("lol_txpcs", EV_TXPCS);
    expect_evt("lol_state", EV_ST_DUAL);
    expect_evt("lol_rxs", EV_RXS_ALL);
    expect_evt("lol_rxp", EV_RXP_ALL);
    expect_evt("lol_txs_fall", EV_TXS_LO);
    expect_evt("lol_link", EV_LINK);
    check("lol_retry", 32'(retry_cnt), 32'd0);

    // PLL never locks: retry then FAIL, then force_retrain
    pll_lol = 1'b1;
    restart();
    exp_q.push_back(T_PDB + T_RST + T_TO);
    exp_q.push_back(T_PDB + 2 * (T_RST + T_TO));
    exp_q.push_back(T_PDB + 2 * (T_RST + T_TO));
    expect_evt("to_retry1", EV_RETRY1);
    expect_evt("to_state_fail", EV_ST_FAIL);
    expect_evt("to_fail", EV_FAIL);
    repeat (3) @(negedge clk);
    check("to_fail_sticky", 32'(fail), 32'd1);
    check("to_retry", 32'(retry_cnt), 32'(MAXR));
    check("to_dual", 32'(serdes_rst_dual_c), 32'd1);
    check("to_txs", 32'(tx_serdes_rst_c), 32'd1);
    check("to_txpcs", 32'(tx_pcs_rst_c), 32'd1);
    check("to_rxs", 32'(rx_serdes_rst_c), 32'd3);
    check("to_rxp", 32'(rx_pcs_rst_c), 32'd3);
    check("to_pdb", 32'(serdes_pdb), 32'd1);
    c0 = cyc;
    force_retrain = 1'b1;
    @(negedge clk);
    force_retrain = 1'b0;
    exp_q.push_back(c0 + 1);
    expect_evt("frc_fail_clr", EV_NOFAIL);
    check("frc_retry", 32'(retry_cnt), 32'd0);
    check("frc_state", 32'(dbg_state), 32'(ST_RST_DUAL));

    // Asynchronous reset in the middle of PLL_WAIT
    repeat (T_RST + 1) @(negedge clk);
    check("mid_state_pllw", 32'(dbg_state), 32'(ST_PLL_WAIT));
    rst = 1'b1;
    #1;
    check_reset("mid");

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
